// File: rtl/sqrt_fp_iter.sv
// Iterative floating-point square root on a shared bidirectional bus.
// Parametrised exponent/mantissa widths; one root bit per clock,
// round-to-nearest-even.
// Optional build macro SQRT_SUBNORMAL_EN: when defined, subnormal operands are
// normalised through a leading-zero count and rooted exactly. When undefined,
// they are flushed to signed zero and no leading-zero counter is built.

module sqrt_fp_iter #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE,
  inout  wire logic [EXP_W+MAN_W:0] IO_DATA,
  output logic                     IS_NAN,
  output logic                     IS_PINF,
  output logic                     IS_NINF,
  output logic                     RESULT,
  output logic                     BUSY
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  // Root width: hidden bit, MAN_W fraction bits, one guard bit.
  localparam int unsigned QW   = MAN_W + 2;
  localparam int unsigned RW   = 2 * QW;
  localparam int unsigned CW   = $clog2(QW + 1);
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  // Signed working width for the unbiased exponent, wide enough for
  // normalised subnormals.
  localparam int unsigned SEW  = EXP_W + $clog2(MAN_W + 1) + 2;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef SQRT_SUBNORMAL_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StNorm, StIter, StRound, StDone} state_e;

  state_e               state_q;
  logic [W-1:0]         op_q;
  logic [CW-1:0]        cnt_q;
  logic [RW-1:0]        rad_q;
  logic [QW+1:0]        rem_q;
  logic [QW-1:0]        root_q;
  logic [EXP_W-1:0]     exp_q;
  logic [W-1:0]         res_q;
  logic                 result_q;
  logic                 busy_q;
  logic                 nan_q;
  logic                 pinf_q;
  logic                 ninf_q;

  // Operand fields.
  logic                 op_sign;
  logic [EXP_W-1:0]     op_exp;
  logic [MAN_W-1:0]     op_man;
  logic                 exp_max;
  logic                 exp_zero;
  logic                 man_zero;

  assign op_sign  = op_q[W-1];
  assign op_exp   = op_q[W-2:MAN_W];
  assign op_man   = op_q[MAN_W-1:0];
  assign exp_max  = &op_exp;
  assign exp_zero = ~|op_exp;
  assign man_zero = ~|op_man;

  // Classification of the latched operand into special results.
  logic                 special;
  logic [W-1:0]         special_res;
  logic                 sp_nan;
  logic                 sp_pinf;
  logic                 sp_ninf;

  // Decide whether the operand bypasses the iteration and what it returns.
  always_comb begin
    special     = 1'b1;
    special_res = '0;
    sp_nan      = 1'b0;
    sp_pinf     = 1'b0;
    sp_ninf     = 1'b0;
    if (exp_max) begin
      if (!man_zero) begin
        special_res = QNAN;
        sp_nan      = 1'b1;
      end else if (!op_sign) begin
        special_res = op_q;
        sp_pinf     = 1'b1;
      end else begin
        special_res = '0;
        sp_ninf     = 1'b1;
      end
    end else if (exp_zero && (man_zero || !SubEn)) begin
      // True zero, or a subnormal flushed to zero: keep the sign.
      special_res = {op_sign, {(W-1){1'b0}}};
    end else if (op_sign) begin
      special_res = QNAN;
      sp_nan      = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  // Normalised significand (hidden bit at MAN_W) and unbiased exponent.
  logic [MAN_W:0]          sig;
  logic signed [SEW-1:0]   e_unb;

`ifdef SQRT_SUBNORMAL_EN
  localparam int unsigned LZW = $clog2(MAN_W + 1);
  logic [LZW-1:0] lz;

  // Shift needed to bring the leading one of a subnormal to the hidden position.
  always_comb begin
    lz = '0;
    for (int i = 0; i < MAN_W; i++) begin
      if (op_man[i]) lz = LZW'(MAN_W - i);
    end
  end

  // Normalise both normal and subnormal operands.
  always_comb begin
    if (exp_zero) begin
      sig   = {1'b0, op_man} << lz;
      e_unb = SEW'(1) - SEW'(BIAS) - SEW'(lz);
    end else begin
      sig   = {1'b1, op_man};
      e_unb = SEW'(op_exp) - SEW'(BIAS);
    end
  end
`else
  // Only normal operands reach the iteration.
  always_comb begin
    sig   = {1'b1, op_man};
    e_unb = SEW'(op_exp) - SEW'(BIAS);
  end
`endif

  // Make the exponent even by doubling the radicand, then halve it.
  logic                  e_odd;
  logic signed [SEW-1:0] e_even;
  logic signed [SEW-1:0] e_half;
  logic [RW-1:0]         rad_init;
  logic [EXP_W-1:0]      exp_init;

  // Radicand alignment: value in [1,4) with 2*(MAN_W+1) fraction bits.
  always_comb begin
    e_odd    = e_unb[0];
    e_even   = e_unb - SEW'(e_odd);
    e_half   = e_even >>> 1;
    exp_init = EXP_W'(e_half + SEW'(BIAS));
    if (e_odd) rad_init = {sig, {(MAN_W+3){1'b0}}};
    else       rad_init = {1'b0, sig, {(MAN_W+2){1'b0}}};
  end

  // One restoring root step: bring down two radicand bits, try subtracting 4q+1.
  logic [QW+1:0] rem_sh;
  logic [QW+1:0] trial;
  logic          ge;
  logic [QW+1:0] rem_nx;
  logic [QW-1:0] root_nx;

  always_comb begin
    rem_sh  = {rem_q[QW-1:0], rad_q[RW-1:RW-2]};
    trial   = {root_q, 2'b01};
    ge      = rem_sh >= trial;
    rem_nx  = ge ? (rem_sh - trial) : rem_sh;
    root_nx = {root_q[QW-2:0], ge};
  end

  // Round to nearest even using the guard bit and a sticky from the remainder.
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [MAN_W:0]   man_rnd;
  logic [EXP_W-1:0] exp_rnd;

  always_comb begin
    guard    = root_q[0];
    sticky   = |rem_q;
    round_up = guard & (sticky | root_q[1]);
    man_rnd  = {1'b0, root_q[MAN_W:1]} + {{MAN_W{1'b0}}, round_up};
    exp_rnd  = exp_q + {{(EXP_W-1){1'b0}}, man_rnd[MAN_W]};
  end

  // Control FSM and datapath registers; all outputs registered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cnt_q    <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      exp_q    <= '0;
      res_q    <= '0;
      result_q <= 1'b0;
      busy_q   <= 1'b0;
      nan_q    <= 1'b0;
      pinf_q   <= 1'b0;
      ninf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ENABLE) begin
            op_q    <= IO_DATA;
            busy_q  <= 1'b1;
            state_q <= StNorm;
          end
        end
        StNorm: begin
          if (!ENABLE) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (special) begin
            res_q    <= special_res;
            nan_q    <= sp_nan;
            pinf_q   <= sp_pinf;
            ninf_q   <= sp_ninf;
            result_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StDone;
          end else begin
            rad_q   <= rad_init;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            exp_q   <= exp_init;
            state_q <= StIter;
          end
        end
        StIter: begin
          if (!ENABLE) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            rad_q  <= rad_q << 2;
            rem_q  <= rem_nx;
            root_q <= root_nx;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(QW - 1)) state_q <= StRound;
          end
        end
        StRound: begin
          if (!ENABLE) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            res_q    <= {1'b0, exp_rnd, man_rnd[MAN_W-1:0]};
            result_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StDone;
          end
        end
        StDone: begin
          // Holding ENABLE high keeps the result; a new request needs a low cycle.
          if (!ENABLE) begin
            result_q <= 1'b0;
            nan_q    <= 1'b0;
            pinf_q   <= 1'b0;
            ninf_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Bus release follows ENABLE combinationally so the host can never collide.
  assign IO_DATA = (result_q && ENABLE) ? res_q : {W{1'bz}};

  assign IS_NAN  = nan_q;
  assign IS_PINF = pinf_q;
  assign IS_NINF = ninf_q;
  assign RESULT  = result_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_sqrt_fp_iter.sv
// Self-checking bench for sqrt_fp_iter: fp16 and fp32 instances, directed
// table, abort/reset sequences and random operands against an integer model.

module tb_sqrt_fp_iter;

`ifdef SQRT_SUBNORMAL_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        en16, en32;
  logic [15:0] d16;
  logic [31:0] d32;
  logic        de16, de32;
  wire  [15:0] bus16;
  wire  [31:0] bus32;
  logic        nan16, pinf16, ninf16, result16, busy16;
  logic        nan32, pinf32, ninf32, result32, busy32;

  int total = 0;
  int bad   = 0;

  assign bus16 = de16 ? d16 : 16'hzzzz;
  assign bus32 = de32 ? d32 : 32'hzzzz_zzzz;

  sqrt_fp_iter #(.EXP_W(5), .MAN_W(10)) u_dut16 (
    .CLK(CLK), .RESET(RESET), .ENABLE(en16), .IO_DATA(bus16),
    .IS_NAN(nan16), .IS_PINF(pinf16), .IS_NINF(ninf16),
    .RESULT(result16), .BUSY(busy16)
  );

  sqrt_fp_iter #(.EXP_W(8), .MAN_W(23)) u_dut32 (
    .CLK(CLK), .RESET(RESET), .ENABLE(en32), .IO_DATA(bus32),
    .IS_NAN(nan32), .IS_PINF(pinf32), .IS_NINF(ninf32),
    .RESULT(result32), .BUSY(busy32)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          f32;
    logic [31:0] op;
    logic [31:0] res;
    logic [2:0]  flg;   // {nan, pinf, ninf}
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    logic [2:0]  flg;
    int          lat;
  } ref_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] bus_of(input bit f32);
    return f32 ? bus32 : {16'h0, bus16};
  endfunction
  function automatic logic [2:0] flg_of(input bit f32);
    return f32 ? {nan32, pinf32, ninf32} : {nan16, pinf16, ninf16};
  endfunction
  function automatic logic res_of(input bit f32);
    return f32 ? result32 : result16;
  endfunction
  function automatic logic busy_of(input bit f32);
    return f32 ? busy32 : busy16;
  endfunction

  task automatic host_drive(input bit f32, input logic [31:0] v, input bit on);
    if (f32) begin d32 = v; de32 = on; end
    else begin d16 = v[15:0]; de16 = on; end
  endtask

  task automatic host_en(input bit f32, input bit v);
    if (f32) en32 = v; else en16 = v;
  endtask

  // The host drives a pattern; it reads back intact only if the block is off the bus.
  task automatic check_released(input bit f32, input string tag);
    logic [31:0] pat;
    pat = f32 ? 32'hA5A5_A5A5 : 32'h0000_A5A5;
    host_drive(f32, pat, 1'b1);
    #1;
    check({tag, " bus released"}, bus_of(f32), pat);
    host_drive(f32, 32'h0, 1'b0);
  endtask

  // Reference: exact integer square root of the scaled significand, then RNE.
  function automatic ref_t ref_sqrt(input logic [31:0] x, input int ew, input int mw);
    ref_t        r;
    int          bias, emax, e, k, s_sh, nbits, sh;
    bit          s, exact, up;
    longint      f, m, n, lo, hi, mid, root, kept, low, half, t;
    logic [31:0] qnan;
    bias = (1 << (ew - 1)) - 1;
    emax = (1 << ew) - 1;
    s    = x[ew + mw];
    e    = int'((x >> mw) & 32'(emax));
    f    = longint'(x & ((32'd1 << mw) - 32'd1));
    qnan = (32'(emax) << mw) | (32'd1 << (mw - 1));
    r.val = '0;
    r.flg = '0;
    r.lat = 1;
    if (e == emax) begin
      if (f != 0) begin r.val = qnan; r.flg = 3'b100; end
      else if (!s) begin r.val = x; r.flg = 3'b010; end
      else begin r.val = '0; r.flg = 3'b001; end
    end else if (e == 0 && (f == 0 || !SubEn)) begin
      r.val = 32'(s) << (ew + mw);
    end else if (s) begin
      r.val = qnan;
      r.flg = 3'b100;
    end else begin
      r.lat = mw + 4;
      if (e == 0) begin m = f; k = 1 - bias - mw; end
      else begin m = f + (longint'(1) << mw); k = e - bias - mw; end
      while (m < (longint'(1) << mw)) begin m = m << 1; k--; end
      if (k % 2 != 0) begin m = m << 1; k--; end
      s_sh = mw / 2 + 4;
      n    = m << (2 * s_sh);
      lo   = 0;
      hi   = longint'(1) << 30;
      while (lo < hi) begin
        mid = (lo + hi + 1) / 2;
        if (mid * mid <= n) lo = mid; else hi = mid - 1;
      end
      root  = lo;
      exact = (root * root == n);
      nbits = 0;
      t     = root;
      while (t > 0) begin t = t >> 1; nbits++; end
      sh   = nbits - (mw + 1);
      kept = root >> sh;
      low  = root & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      up   = (low > half) || (low == half && (!exact || (kept % 2 == 1)));
      if (up) kept++;
      if (kept == (longint'(1) << (mw + 1))) begin kept = kept >> 1; nbits++; end
      r.val = (32'((nbits - 1) + k / 2 - s_sh + bias) << mw)
            | 32'(kept & ((longint'(1) << mw) - 1));
    end
    return r;
  endfunction

  // Full transaction: load, wait for RESULT, check value/flags/latency, hold, release.
  task automatic run_op(input bit f32, input logic [31:0] op, input logic [31:0] eres,
                        input logic [2:0] eflg, input int elat, input string tag);
    int lat;
    lat = -1;
    host_drive(f32, op, 1'b1);
    host_en(f32, 1'b1);
    @(posedge CLK);
    #1;
    host_drive(f32, 32'h0, 1'b0);
    check({tag, " busy after load"}, 32'(busy_of(f32)), 32'd1);
    for (int i = 1; i <= 60 && lat < 0; i++) begin
      @(posedge CLK);
      #1;
      if (res_of(f32)) lat = i;
    end
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " value"}, bus_of(f32), eres);
    check({tag, " flags"}, 32'(flg_of(f32)), 32'(eflg));
    check({tag, " busy at result"}, 32'(busy_of(f32)), 32'd0);
    @(posedge CLK);
    #1;
    check({tag, " held value"}, {31'h0, res_of(f32)} ^ (bus_of(f32) ^ eres), 32'd1);
    host_en(f32, 1'b0);
    check_released(f32, tag);
    @(posedge CLK);
    #1;
    check({tag, " result cleared"}, {28'h0, flg_of(f32), res_of(f32)}, 32'd0);
  endtask

  vec_t vt[14];

  initial begin
    ref_t        rr;
    logic [31:0] op;
    bit          seen;

    vt[0]  = '{1'b0, 32'h3C00, 32'h3C00, 3'b000, 14};
    vt[1]  = '{1'b0, 32'h4400, 32'h4000, 3'b000, 14};
    vt[2]  = '{1'b0, 32'h4000, 32'h3DA8, 3'b000, 14};
    vt[3]  = '{1'b0, 32'h7C00, 32'h7C00, 3'b010, 1};
    vt[4]  = '{1'b0, 32'hFC00, 32'h0000, 3'b001, 1};
    vt[5]  = '{1'b0, 32'h7E00, 32'h7E00, 3'b100, 1};
    vt[6]  = '{1'b0, 32'hBC00, 32'h7E00, 3'b100, 1};
    vt[7]  = '{1'b0, 32'h8000, 32'h8000, 3'b000, 1};
    vt[8]  = '{1'b0, 32'h0000, 32'h0000, 3'b000, 1};
    vt[9]  = '{1'b0, 32'hFE01, 32'h7E00, 3'b100, 1};
    vt[10] = '{1'b0, 32'h0001, SubEn ? 32'h0C00 : 32'h0000, 3'b000, SubEn ? 14 : 1};
    vt[11] = '{1'b1, 32'h4080_0000, 32'h4000_0000, 3'b000, 27};
    vt[12] = '{1'b1, 32'h4000_0000, 32'h3FB5_04F3, 3'b000, 27};
    vt[13] = '{1'b1, 32'hFF80_0000, 32'h0000_0000, 3'b001, 1};

    RESET = 1'b1;
    en16  = 1'b0;
    en32  = 1'b0;
    de16  = 1'b0;
    de32  = 1'b0;
    d16   = '0;
    d32   = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset fp16 outputs", {27'h0, flg_of(1'b0), res_of(1'b0), busy_of(1'b0)}, 32'd0);
    check("reset fp32 outputs", {27'h0, flg_of(1'b1), res_of(1'b1), busy_of(1'b1)}, 32'd0);
    check_released(1'b0, "reset fp16");
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 14; i++) begin
      run_op(vt[i].f32, vt[i].op, vt[i].res, vt[i].flg, vt[i].lat,
             $sformatf("vec%0d %h", i, vt[i].op));
    end

    // Abort: ENABLE falls before edge 5.
    host_drive(1'b0, 32'h4400, 1'b1);
    en16 = 1'b1;
    @(posedge CLK);
    #1;
    host_drive(1'b0, 32'h0, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    en16 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      if (result16) seen = 1'b1;
    end
    check("abort result never", 32'(seen), 32'd0);
    check("abort busy", 32'(busy16), 32'd0);
    check_released(1'b0, "abort");
    @(posedge CLK);
    #1;
    run_op(1'b0, 32'h4400, 32'h4000, 3'b000, 14, "after abort");

    // Reset pulse during the iteration.
    host_drive(1'b0, 32'h4000, 1'b1);
    en16 = 1'b1;
    @(posedge CLK);
    #1;
    host_drive(1'b0, 32'h0, 1'b0);
    repeat (5) @(posedge CLK);
    #1;
    check("pre-reset busy", 32'(busy16), 32'd1);
    RESET = 1'b1;
    #1;
    check("mid reset outputs", {27'h0, flg16_pack(), result16, busy16}, 32'd0);
    check_released(1'b0, "mid reset");
    en16  = 1'b0;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    run_op(1'b0, 32'h4000, 32'h3DA8, 3'b000, 14, "after reset");

    // Random fp16 operands, mostly positive.
    for (int i = 0; i < 150; i++) begin
      op = 32'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) op[15] = 1'b0;
      rr = ref_sqrt(op, 5, 10);
      run_op(1'b0, op, rr.val, rr.flg, rr.lat, $sformatf("rnd16 %h", op));
    end

    // Random fp32 operands.
    for (int i = 0; i < 30; i++) begin
      op = $urandom;
      if ($urandom_range(0, 3) != 0) op[31] = 1'b0;
      rr = ref_sqrt(op, 8, 23);
      run_op(1'b1, op, rr.val, rr.flg, rr.lat, $sformatf("rnd32 %h", op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [2:0] flg16_pack();
    return {nan16, pinf16, ninf16};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
